// File: rtl/aes_round_key_buffer.sv
// ============================================================================
// aes_round_key_buffer
// ----------------------------------------------------------------------------
// Stores the expanded AES key schedule (NW = 4*(NR+1) 32-bit words) as it is
// produced by a key-expansion engine, then serves complete 128-bit round keys
// with a fixed one-cycle read latency.
//
// Optional feature (compile-time macro AES_KEYBUF_ZEROIZE_EN):
//   When defined, 'clear' walks the whole buffer writing zeros (one word per
//   cycle) before the block returns to EMPTY. When undefined, 'clear' only
//   resets the pointer and state; stale words remain but can never be read
//   because a round key is only returned after a complete reload.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-low reset
//   clear     in   synchronous flush (wins over a same-cycle write or read)
//   wr_valid  in   key-schedule word present on wr_word
//   wr_word   in   [31:0] expanded key word, w[0] first
//   wr_ready  out  buffer accepts a word this cycle
//   full      out  all NW words stored, round keys readable
//   rd_req    in   single-cycle request for one round key
//   rd_round  in   [3:0] requested round, 0..NR
//   rd_valid  out  one-cycle pulse, rd_key valid
//   rd_key    out  [127:0] {w[4r], w[4r+1], w[4r+2], w[4r+3]}
//   rd_err    out  one-cycle pulse, request rejected (rd_key forced to 0)
//   busy      out  loading or zeroizing
// ============================================================================
module aes_round_key_buffer #(
    parameter int NR = 14
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         wr_valid,
    input  logic [31:0]  wr_word,
    output logic         wr_ready,
    output logic         full,
    input  logic         rd_req,
    input  logic [3:0]   rd_round,
    output logic         rd_valid,
    output logic [127:0] rd_key,
    output logic         rd_err,
    output logic         busy
);

    localparam int NW = 4 * (NR + 1);
    localparam int PW = $clog2(NW);
    localparam logic [PW-1:0] LAST_IDX  = PW'(NW - 1);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [3:0]    MAX_ROUND = 4'(NR);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
`ifdef AES_KEYBUF_ZEROIZE_EN
        ,
        ZERO  = 2'd3
`endif
    } state_t;

    state_t          state_reg, state_next;
    logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
    // Low during reset and for the first edge after it, so wr_ready stays
    // low while rst is asserted even though the state decodes as EMPTY.
    logic            run_reg;

`ifdef AES_KEYBUF_ZEROIZE_EN
    logic [PW-1:0]   zero_ptr_reg, zero_ptr_next;
`endif

    // Single shared write port: either a loaded key word or a zeroizing write.
    logic            mem_we;
    logic [PW-1:0]   mem_idx;
    logic [31:0]     mem_wdata;

    logic            rd_ok;
    logic [3:0]      rd_addr;
    logic [31:0]     bank_word [4];

    logic            rd_valid_reg;
    logic            rd_err_reg;
    logic [127:0]    rd_key_reg;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= EMPTY;
            wr_ptr_reg   <= '0;
            run_reg      <= 1'b0;
`ifdef AES_KEYBUF_ZEROIZE_EN
            zero_ptr_reg <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            wr_ptr_reg   <= wr_ptr_next;
            run_reg      <= 1'b1;
`ifdef AES_KEYBUF_ZEROIZE_EN
            zero_ptr_reg <= zero_ptr_next;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        wr_ptr_next   = wr_ptr_reg;
        wr_ready      = 1'b0;
        full          = 1'b0;
        busy          = 1'b0;
        mem_we        = 1'b0;
        mem_idx       = wr_ptr_reg;
        mem_wdata     = wr_word;
`ifdef AES_KEYBUF_ZEROIZE_EN
        zero_ptr_next = zero_ptr_reg;
`endif

        case (state_reg)
            EMPTY: begin
                wr_ready = run_reg;
            end
            LOAD: begin
                wr_ready = run_reg;
                busy     = 1'b1;
            end
            READY: begin
                full = 1'b1;
            end
`ifdef AES_KEYBUF_ZEROIZE_EN
            ZERO: begin
                busy          = 1'b1;
                mem_we        = 1'b1;
                mem_idx       = zero_ptr_reg;
                mem_wdata     = '0;
                zero_ptr_next = zero_ptr_reg + PTR_ONE;
                if (zero_ptr_reg == LAST_IDX) begin
                    state_next = EMPTY;
                end
            end
`endif
            default: begin
                state_next = EMPTY;
            end
        endcase

        if (clear) begin
            // Flush wins over anything else this cycle, including the
            // zeroizing write (a clear during ZERO restarts from word 0).
            wr_ptr_next   = '0;
            mem_we        = 1'b0;
`ifdef AES_KEYBUF_ZEROIZE_EN
            zero_ptr_next = '0;
            state_next    = ZERO;
`else
            state_next    = EMPTY;
`endif
        end else if (wr_valid && wr_ready) begin
            mem_we      = 1'b1;
            mem_idx     = wr_ptr_reg;
            mem_wdata   = wr_word;
            wr_ptr_next = wr_ptr_reg + PTR_ONE;
            if (wr_ptr_reg == LAST_IDX) begin
                state_next = READY;
            end else begin
                state_next = LOAD;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Storage: four word banks, one per column of a round key, so a whole
    // round key is fetched in one access. Word i lives in bank i%4 at i/4.
    // ------------------------------------------------------------------------
    assign rd_ok   = rd_req && !clear && (state_reg == READY) && (rd_round <= MAX_ROUND);
    // Keep the array index in range even for rejected requests.
    assign rd_addr = (rd_round <= MAX_ROUND) ? rd_round : 4'd0;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : gen_bank
            logic [31:0] bank_mem [0:NR];

            always_ff @(posedge clk) begin
                if (mem_we && (mem_idx[1:0] == 2'(gi))) begin
                    bank_mem[mem_idx[PW-1:2]] <= mem_wdata;
                end
            end

            assign bank_word[gi] = bank_mem[rd_addr];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Read response register: one-cycle latency, key held between pulses,
    // forced to zero on a rejected request.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid_reg <= 1'b0;
            rd_err_reg   <= 1'b0;
            rd_key_reg   <= '0;
        end else begin
            rd_valid_reg <= rd_ok;
            rd_err_reg   <= rd_req && !rd_ok;
            if (rd_ok) begin
                rd_key_reg <= {bank_word[0], bank_word[1], bank_word[2], bank_word[3]};
            end else if (rd_req) begin
                rd_key_reg <= '0;
            end
        end
    end

    assign rd_valid = rd_valid_reg;
    assign rd_err   = rd_err_reg;
    assign rd_key   = rd_key_reg;

endmodule

// File: tb/tb_aes_round_key_buffer.sv
module tb_aes_round_key_buffer;

    logic         clk;
    logic         rst;
    logic         clear;
    logic         wr_valid;
    logic [31:0]  wr_word;
    logic         wr_ready;
    logic         full;
    logic         rd_req;
    logic [3:0]   rd_round;
    logic         rd_valid;
    logic [127:0] rd_key;
    logic         rd_err;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic         err;
        logic [127:0] key;
        int           due;
        int           id;
    } exp_t;

    exp_t exp_q[$];
    int   req_id = 0;

    aes_round_key_buffer #(.NR(14)) dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .wr_valid (wr_valid),
        .wr_word  (wr_word),
        .wr_ready (wr_ready),
        .full     (full),
        .rd_req   (rd_req),
        .rd_round (rd_round),
        .rd_valid (rd_valid),
        .rd_key   (rd_key),
        .rd_err   (rd_err),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    function automatic logic [127:0] rkey(input logic [31:0] base, input int r);
        logic [31:0] w0;
        w0 = base + 32'(4 * r);
        return {w0, w0 + 32'd1, w0 + 32'd2, w0 + 32'd3};
    endfunction

    // Issue one read request for the current cycle and record its expected response.
    task automatic issue_rd(input logic [3:0] r, input logic err, input logic [127:0] key);
        exp_t e;
        e.err = err;
        e.key = key;
        e.due = cyc + 1;
        e.id  = req_id++;
        exp_q.push_back(e);
        rd_req   = 1'b1;
        rd_round = r;
        tick();
        rd_req   = 1'b0;
    endtask

    task automatic load(input logic [31:0] base, input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            wr_valid = 1'b1;
            wr_word  = base + 32'(i);
            tick();
            if (gap) begin
                wr_valid = 1'b0;
                tick();
            end
        end
        wr_valid = 1'b0;
    endtask

`ifdef AES_KEYBUF_ZEROIZE_EN
    task automatic wait_zero(input string name);
        int n;
        n = 0;
        while (busy && n < 200) begin
            n++;
            tick();
        end
        chk(name, 128'(n), 128'd60);
        chk({name, "_w0"},  128'(dut.gen_bank[0].bank_mem[0]),  128'd0);
        chk({name, "_w59"}, 128'(dut.gen_bank[3].bank_mem[14]), 128'd0);
    endtask
`endif

    // Monitor: pops the scoreboard whenever the DUT presents a read response.
    always @(negedge clk) begin
        if (rst && (rd_valid || rd_err)) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_unexpected: got valid=%0b err=%0b key=%0h required no response",
                         rd_valid, rd_err, rd_key);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (rd_err !== e.err || rd_valid !== !e.err || rd_key !== e.key || cyc != e.due) begin
                    n_fail++;
                    $display("FAIL rd_resp#%0d: got valid=%0b err=%0b key=%0h cyc=%0d required valid=%0b err=%0b key=%0h cyc=%0d",
                             e.id, rd_valid, rd_err, rd_key, cyc, !e.err, e.err, e.key, e.due);
                end else begin
                    $display("ok   rd_resp#%0d: err=%0b key=%0h", e.id, rd_err, rd_key);
                end
            end
        end
    end

    initial begin
        rst      = 1'b0;
        clear    = 1'b0;
        wr_valid = 1'b0;
        wr_word  = '0;
        rd_req   = 1'b0;
        rd_round = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_full",     128'(full),     128'd0);
        chk("rst_wr_ready", 128'(wr_ready), 128'd0);
        chk("rst_rd_valid", 128'(rd_valid), 128'd0);
        chk("rst_rd_err",   128'(rd_err),   128'd0);
        chk("rst_rd_key",   rd_key,         128'd0);
        chk("rst_busy",     128'(busy),     128'd0);
        rst = 1'b1;
        tick();
        chk("post_rst_wr_ready", 128'(wr_ready), 128'd1);

        // Read in EMPTY is rejected
        issue_rd(4'd0, 1'b1, 128'd0);

        // Full load, no gaps
        load(32'h1000_0000, 30, 1'b0);
        chk("mid_load_busy", 128'(busy), 128'd1);
        chk("mid_load_full", 128'(full), 128'd0);
        for (int i = 30; i < 60; i++) begin
            wr_valid = 1'b1;
            wr_word  = 32'h1000_0000 + 32'(i);
            tick();
        end
        wr_valid = 1'b0;
        chk("load_full",     128'(full),     128'd1);
        chk("load_wr_ready", 128'(wr_ready), 128'd0);
        chk("load_busy",     128'(busy),     128'd0);

        // Write while full must be ignored
        wr_valid = 1'b1;
        wr_word  = 32'hDEAD_BEEF;
        tick();
        wr_valid = 1'b0;

        // Reads of round 0 then 14 back to back, then illegal round
        issue_rd(4'd0,  1'b0, 128'h10000000_10000001_10000002_10000003);
        issue_rd(4'd14, 1'b0, 128'h10000038_10000039_1000003A_1000003B);
        issue_rd(4'd15, 1'b1, 128'd0);
        for (int r = 0; r <= 14; r++) begin
            issue_rd(4'(r), 1'b0, rkey(32'h1000_0000, r));
        end
        tick();
        tick();
        chk("rd_key_hold", rd_key, 128'h10000038_10000039_1000003A_1000003B);

        // Clear with a simultaneous read: read is rejected
        clear = 1'b1;
        issue_rd(4'd3, 1'b1, 128'd0);
        clear = 1'b0;
        chk("clear_full", 128'(full), 128'd0);
`ifdef AES_KEYBUF_ZEROIZE_EN
        chk("clear_busy", 128'(busy), 128'd1);
        wait_zero("zero_cycles_a");
`else
        chk("clear_wr_ready", 128'(wr_ready), 128'd1);
`endif

        // Reset in the middle of a gapped load
        load(32'h2000_0000, 20, 1'b1);
        chk("gap_load_busy", 128'(busy), 128'd1);
        chk("gap_load_full", 128'(full), 128'd0);
        rst = 1'b0;
        #1;
        chk("midrst_full",     128'(full),           128'd0);
        chk("midrst_busy",     128'(busy),           128'd0);
        chk("midrst_wr_ready", 128'(wr_ready),       128'd0);
        chk("midrst_wr_ptr",   128'(dut.wr_ptr_reg), 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        chk("rerst_wr_ready", 128'(wr_ready), 128'd1);

        // Fresh full load after reset reads back correctly
        load(32'hA500_0000, 60, 1'b0);
        chk("reload_full", 128'(full), 128'd1);
        issue_rd(4'd0,  1'b0, rkey(32'hA500_0000, 0));
        issue_rd(4'd7,  1'b0, rkey(32'hA500_0000, 7));
        issue_rd(4'd14, 1'b0, rkey(32'hA500_0000, 14));

        // Clear, then 59 words, then the 60th word collides with clear
        clear = 1'b1;
        tick();
        clear = 1'b0;
`ifdef AES_KEYBUF_ZEROIZE_EN
        wait_zero("zero_cycles_b");
`endif
        load(32'h3000_0000, 59, 1'b0);
        wr_valid = 1'b1;
        wr_word  = 32'h3000_003B;
        clear    = 1'b1;
        tick();
        wr_valid = 1'b0;
        clear    = 1'b0;
        chk("clear_vs_write_full", 128'(full), 128'd0);
        tick();
        chk("clear_vs_write_full2", 128'(full), 128'd0);
`ifdef AES_KEYBUF_ZEROIZE_EN
        chk("clear_vs_write_busy", 128'(busy), 128'd1);
`else
        chk("clear_vs_write_ready", 128'(wr_ready), 128'd1);
        issue_rd(4'd1, 1'b1, 128'd0);
`endif

        repeat (3) tick();
        chk("pending_responses", 128'(exp_q.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_round_key_buffer.md
AES_ROUND_KEY_BUFFER -- requirements
Module: aes_round_key_buffer

Interface
REQ-001: Parameter NR, default 14, number of AES rounds (legal values 10, 12, 14); the buffer SHALL hold NW = 4*(NR+1) words.
REQ-002: Clock and reset SHALL be: reset rst, asynchronous, active-low; clock clk.
REQ-003: clk  input  1  rising-edge clock for all state.
REQ-004: rst  input  1  asynchronous active-low reset.
REQ-005: clear  input  1  synchronous flush of buffer contents and counters.
REQ-006: wr_valid  input  1  a key-schedule word is presented on wr_word.
REQ-007: wr_word  input  32  expanded key word; w[0] arrives first.
REQ-008: wr_ready  output  1  buffer accepts a word this cycle.
REQ-009: full  output  1  all NW words are stored; round keys are readable.
REQ-010: rd_req  input  1  single-cycle request for one round key.
REQ-011: rd_round  input  4  round index of the request, 0..NR.
REQ-012: rd_valid  output  1  one-cycle pulse; rd_key is valid.
REQ-013: rd_key  output  128  round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}, with w[4r] in bits [127:96].
REQ-014: rd_err  output  1  one-cycle pulse on an illegal request.
REQ-015: busy  output  1  the block is in LOAD or ZERO.

Function
REQ-016: States SHALL be EMPTY, LOAD, READY, and ZERO; ZERO exists only when the macro in REQ-033 is defined.
REQ-017: A write SHALL occur when wr_valid && wr_ready; the word is stored at index wr_ptr, and wr_ptr then increments.
REQ-018: wr_ready SHALL be 1 in EMPTY and LOAD, and 0 in READY and ZERO.
REQ-019: EMPTY -> LOAD on the first write; LOAD -> READY on the write at wr_ptr = NW-1, with full=1 from the next cycle.
REQ-020: wr_valid while wr_ready=0 SHALL be ignored: no storage change and no error.
REQ-021: Gaps in wr_valid during LOAD SHALL be tolerated; wr_ptr holds its value.
REQ-022: Read latency SHALL be 1 cycle: rd_req at cycle N gives rd_valid or rd_err at cycle N+1.
REQ-023: rd_req in READY with rd_round <= NR SHALL give rd_valid=1 and rd_key per REQ-013.
REQ-024: rd_req with rd_round > NR, or in any state other than READY, SHALL give rd_err=1, rd_valid=0, rd_key=0.
REQ-025: When no rd_valid pulse occurs, rd_key SHALL hold its last value.
REQ-026: Back-to-back rd_req on consecutive cycles SHALL each produce a response; throughput is 1 key per cycle.
REQ-027: clear SHALL take priority over a write and a read in the same cycle: the write is dropped and the read returns rd_err.
REQ-028: Without the macro, clear SHALL give wr_ptr=0, full=0, and state EMPTY on the next cycle; stored words are left undefined-but-unused.

Reset
REQ-029: On rst=0 the state SHALL be EMPTY and wr_ptr=0.
REQ-030: On rst=0 the outputs SHALL be full=0, wr_ready=0 during reset, rd_valid=0, rd_err=0, rd_key=0, busy=0.
REQ-031: wr_ready SHALL rise in the first cycle after rst deasserts.
REQ-032: Reset mid-LOAD or mid-ZERO SHALL abort immediately; storage contents are not cleared by rst.

Configuration
REQ-033: With macro AES_KEYBUF_ZEROIZE_EN defined, clear SHALL enter ZERO, which writes 0 to one word per cycle from index 0 to NW-1, then goes to EMPTY.
REQ-034: During ZERO the outputs SHALL be busy=1 and wr_ready=0; rd_req gives rd_err; a further clear restarts zeroization at index 0.
REQ-035: Without AES_KEYBUF_ZEROIZE_EN, the ZERO state and its zeroization counter SHALL not be present, and clear behaves per REQ-028.

Verification
REQ-036: Scenario, NR=14 load: feed w[i]=32'h1000_0000+i for i=0..59 with no gaps -> full=1 one cycle after the 60th write, and wr_ready=0.
REQ-037: Scenario, full buffer reads: rd_req with rd_round=0, then 14 on consecutive cycles -> rd_key=0x10000000_10000001_10000002_10000003, then 0x10000038_10000039_1000003A_1000003B, each with rd_valid.
REQ-038: Scenario, illegal reads: rd_round=15 on a full buffer -> rd_err=1, rd_key=0; rd_req in EMPTY -> rd_err=1.
REQ-039: Scenario, reset mid-load: load 20 gapped words, then pulse rst -> full=0 and wr_ptr=0; a fresh load of 60 words then reads back correctly.
REQ-040: Scenario, clear with a simultaneous write on the 60th word -> the write is dropped and full stays 0.
REQ-041: Scenario, AES_KEYBUF_ZEROIZE_EN defined: clear on a full buffer -> busy=1 for exactly 60 cycles, then EMPTY; internal words read as 0.
